// File: rtl/ram_pkg.sv
// ram_pkg: shared types and elaboration helpers for the arbitrated RAM slice
package ram_pkg;
  typedef enum logic {OP_WRITE = 1'b0, OP_READ = 1'b1} op_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts one past the last granted index
module rr_arbiter
  import ram_pkg::*;
#(
  parameter int P_ports = 2
) (
  input  logic               G_clock,
  input  logic               G_reset_n,
  input  logic [P_ports-1:0] req,
  output logic [P_ports-1:0] gnt
);
  localparam int LW = P_ports > 1 ? clog2(P_ports) : 1;
  logic [LW-1:0] last, nxt;
  always_comb begin
    nxt = last;
    // descending offsets so the closest requester after last overwrites the rest
    for (int k = P_ports; k >= 1; k--)
      for (int i = 0; i < P_ports; i++)
        if (req[i] && i == (int'(last) + k) % P_ports) nxt = LW'(i);
    gnt = '0;
    if (G_reset_n && |req) gnt[nxt] = 1'b1;
  end
  always_ff @(posedge G_clock)
    if (!G_reset_n) last <= LW'(P_ports - 1);
    else if (|gnt) last <= nxt;
endmodule

// File: rtl/arbitrated_ram.sv
// arbitrated_ram: single-port RAM shared by P_ports request/grant channels
module arbitrated_ram
  import ram_pkg::*;
#(
  parameter  int P_size  = 1024,
  parameter  int P_width = 8,
  parameter  int P_ports = 2,
  localparam int A       = clog2(P_size)
) (
  input  logic                       G_clock,
  input  logic                       G_reset_n,
  input  logic [P_ports-1:0]         G_req,
  input  logic [P_ports-1:0]         G_rdwr,
  input  logic [P_ports*A-1:0]       G_addr,
  input  logic [P_ports*P_width-1:0] G_wr_data,
  output logic [P_ports-1:0]         G_gnt,
  output logic [P_ports-1:0]         G_rd_valid,
  output logic [P_ports*P_width-1:0] G_rd_data
);
  logic [P_width-1:0] mem [P_size];
  logic [A-1:0]       s_addr;
  logic [P_width-1:0] s_wd, s_rd;
  op_t                s_op;
  logic               in_range;
  rr_arbiter #(.P_ports(P_ports)) u_arb (
    .G_clock   (G_clock),
    .G_reset_n (G_reset_n),
    .req       (G_req),
    .gnt       (G_gnt)
  );
  always_comb begin
    s_addr = '0;
    s_wd   = '0;
    s_op   = OP_WRITE;
    for (int i = 0; i < P_ports; i++)
      if (G_gnt[i]) begin
        s_addr = G_addr[i*A +: A];
        s_wd   = G_wr_data[i*P_width +: P_width];
        s_op   = op_t'(G_rdwr[i]);
      end
    in_range = int'(s_addr) < P_size;
    s_rd     = in_range ? mem[s_addr] : '0;
  end
  always_ff @(posedge G_clock)
    if (|G_gnt && s_op == OP_WRITE && in_range) mem[s_addr] <= s_wd;
  always_ff @(posedge G_clock)
    if (!G_reset_n) begin
      G_rd_valid <= '0;
      G_rd_data  <= '0;
    end else begin
      G_rd_valid <= s_op == OP_READ ? G_gnt : '0;
      for (int i = 0; i < P_ports; i++)
        if (G_gnt[i] && s_op == OP_READ) G_rd_data[i*P_width +: P_width] <= s_rd;
    end
endmodule

// File: tb/tb_arbitrated_ram.sv
// tb_arbitrated_ram: directed checks on a 1024-word and a 1000-word 3-channel instance
module tb_arbitrated_ram;
  logic        clk, rst_n;
  logic [2:0]  req, rdwr;
  logic [29:0] addr;
  logic [23:0] wd;
  logic [2:0]  gnt_a, gnt_b, rv_a, rv_b;
  logic [23:0] rd_a, rd_b;
  int total, bad;

  arbitrated_ram #(.P_size(1024), .P_width(8), .P_ports(3)) u_a (
    .G_clock(clk), .G_reset_n(rst_n), .G_req(req), .G_rdwr(rdwr), .G_addr(addr),
    .G_wr_data(wd), .G_gnt(gnt_a), .G_rd_valid(rv_a), .G_rd_data(rd_a));
  arbitrated_ram #(.P_size(1000), .P_width(8), .P_ports(3)) u_b (
    .G_clock(clk), .G_reset_n(rst_n), .G_req(req), .G_rdwr(rdwr), .G_addr(addr),
    .G_wr_data(wd), .G_gnt(gnt_b), .G_rd_valid(rv_b), .G_rd_data(rd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input int ch, input bit rd, input int ad, input logic [7:0] d);
    req = '0;
    req[ch] = 1'b1;
    rdwr[ch] = rd;
    addr[ch*10 +: 10] = 10'(ad);
    wd[ch*8 +: 8] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 3'b111;
    rdwr = 3'b111;
    addr = '0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (gnt_a !== 3'b000 || gnt_b !== 3'b000) begin
        bad++; $display("FAIL reset_gnt got=%b/%b want=000", gnt_a, gnt_b);
      end
      step();
      total++;
      if (rv_a !== 3'b000 || rd_a !== 24'h0 || rd_b !== 24'h0) begin
        bad++; $display("FAIL reset_out rv=%b rd_a=%h rd_b=%h want 0", rv_a, rd_a, rd_b);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b001) begin bad++; $display("FAIL first_gnt got=%b want=001", gnt_a); end
    step();
    total++;
    if (rv_a !== 3'b001) begin bad++; $display("FAIL first_rv got=%b want=001", rv_a); end
    req = '0;
  endtask

  task automatic test_single();
    issue(0, 0, 'h3FF, 8'hA5);
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b001 || gnt_b !== 3'b001) begin
      bad++; $display("FAIL single_wr_gnt got=%b/%b want=001", gnt_a, gnt_b);
    end
    step();
    total++;
    if (rv_a !== 3'b000) begin bad++; $display("FAIL single_wr_rv got=%b want=000", rv_a); end
    issue(0, 1, 'h3FF, 8'h00);
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b001) begin bad++; $display("FAIL single_rd_gnt got=%b want=001", gnt_a); end
    step();
    req = '0;
    total++;
    if (rd_a[7:0] !== 8'hA5 || rv_a !== 3'b001) begin
      bad++; $display("FAIL single_rd got=%h rv=%b want=a5 rv=001", rd_a[7:0], rv_a);
    end
    total++;
    if (rd_b[7:0] !== 8'h00 || rv_b !== 3'b001) begin
      bad++; $display("FAIL single_oor_rd got=%h rv=%b want=00 rv=001", rd_b[7:0], rv_b);
    end
    step();
    total++;
    if (rv_a !== 3'b000) begin bad++; $display("FAIL single_pulse got=%b want=000", rv_a); end
  endtask

  task automatic test_raw();
    issue(1, 0, 7, 8'h5C);
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b010) begin bad++; $display("FAIL raw_wr_gnt got=%b want=010", gnt_a); end
    step();
    issue(0, 1, 7, 8'h00);
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b001) begin bad++; $display("FAIL raw_rd_gnt got=%b want=001", gnt_a); end
    step();
    req = '0;
    total++;
    if (rd_a[7:0] !== 8'h5C || rd_a[15:8] !== 8'h00 || rv_a !== 3'b001) begin
      bad++; $display("FAIL raw_rd got=%h rv=%b want=005c rv=001", rd_a[15:0], rv_a);
    end
  endtask

  task automatic test_oor();
    issue(2, 0, 999, 8'h42);
    step();
    issue(2, 0, 1000, 8'hFF);
    @(negedge clk);
    total++;
    if (gnt_b !== 3'b100) begin bad++; $display("FAIL oor_wr_gnt got=%b want=100", gnt_b); end
    step();
    issue(2, 1, 1000, 8'h00);
    step();
    total++;
    if (rd_b[23:16] !== 8'h00 || rv_b !== 3'b100) begin
      bad++; $display("FAIL oor_rd got=%h rv=%b want=00 rv=100", rd_b[23:16], rv_b);
    end
    total++;
    if (rd_a[23:16] !== 8'hFF) begin bad++; $display("FAIL inrange_1000 got=%h want=ff", rd_a[23:16]); end
    issue(2, 1, 999, 8'h00);
    step();
    req = '0;
    total++;
    if (rd_b[23:16] !== 8'h42 || rd_a[23:16] !== 8'h42) begin
      bad++; $display("FAIL oor_999 got=%h/%h want=42", rd_b[23:16], rd_a[23:16]);
    end
  endtask

  task automatic test_contention();
    int ord [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] exp;
    rst_n = 1'b0;
    req = '0;
    step();
    rst_n = 1'b1;
    addr = {10'd4, 10'd7, 10'h3FF};
    rdwr = 3'b111;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp = 3'(1 << ord[k]);
      @(negedge clk);
      total++;
      if (gnt_a !== exp) begin bad++; $display("FAIL cont_gnt%0d got=%b want=%b", k, gnt_a, exp); end
      step();
      total++;
      if (rv_a !== exp) begin bad++; $display("FAIL cont_rv%0d got=%b want=%b", k, rv_a, exp); end
      if (ord[k] == 0) begin
        total++;
        if (rd_a[7:0] !== 8'hA5) begin bad++; $display("FAIL cont_d0 got=%h want=a5", rd_a[7:0]); end
      end
      if (ord[k] == 1) begin
        total++;
        if (rd_a[15:8] !== 8'h5C) begin bad++; $display("FAIL cont_d1 got=%h want=5c", rd_a[15:8]); end
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    issue(2, 0, 4, 8'h77);
    step();
    addr = {10'd4, 10'd4, 10'd4};
    wd[23:16] = 8'h11;
    rdwr = 3'b001;
    req = 3'b101;
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b001) begin bad++; $display("FAIL mid_pre_gnt got=%b want=001", gnt_a); end
    step();
    total++;
    if (rd_a[7:0] !== 8'h77 || rv_a !== 3'b001) begin
      bad++; $display("FAIL mid_pre_rd got=%h rv=%b want=77 rv=001", rd_a[7:0], rv_a);
    end
    req = 3'b100;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b000 || gnt_b !== 3'b000) begin
      bad++; $display("FAIL mid_gnt got=%b/%b want=000", gnt_a, gnt_b);
    end
    step();
    total++;
    if (rv_a !== 3'b000 || rd_a !== 24'h0) begin
      bad++; $display("FAIL mid_clear rv=%b rd=%h want 0", rv_a, rd_a);
    end
    rst_n = 1'b1;
    rdwr = 3'b011;
    req = 3'b011;
    @(negedge clk);
    total++;
    if (gnt_a !== 3'b001) begin bad++; $display("FAIL mid_ptr got=%b want=001", gnt_a); end
    step();
    req = '0;
    total++;
    if (rd_a[7:0] !== 8'h77) begin bad++; $display("FAIL mid_mem got=%h want=77", rd_a[7:0]); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    req = '0;
    rdwr = '0;
    addr = '0;
    wd = '0;
    test_reset();
    test_single();
    test_raw();
    test_oor();
    test_contention();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
